// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//
// Debounces and edge-classifies the raw alarm-panel keys. The divided 50 Hz
// clock from the upstream divider is used purely as a sampling strobe: it is
// synchronised into the CLK domain and its rising edges become a one-cycle
// tick_ev. Every piece of key state advances only on tick_ev.
//
// Parameters:
//   N_KEYS     - number of independent key inputs
//   STABLE     - consecutive disagreeing tick samples needed to flip a
//                debounced level (1..15)
//   HOLD_TICKS - ticks a key must stay pressed before KEY_LONG fires
//                (1..1023)
//
// Ports:
//   CLK         in   1       system clock
//   RST         in   1       asynchronous reset, active-high
//   TICK        in   1       divided-clock level, asynchronous, rising edges used
//   KEY_IN      in   N_KEYS  raw key contacts, active-low, asynchronous
//   KEY_LVL     out  N_KEYS  debounced level, active-high
//   KEY_PRESS   out  N_KEYS  one-CLK pulse on KEY_LVL 0->1
//   KEY_RELEASE out  N_KEYS  one-CLK pulse on KEY_LVL 1->0
//   KEY_LONG    out  N_KEYS  one-CLK pulse once per press after HOLD_TICKS
//
// Latency from a TICK rising edge to an output change is 4 CLK:
// 2 synchroniser flops, 1 registered edge detect, 1 output register.
// ----------------------------------------------------------------------------
module key_debounce #(
   parameter int N_KEYS     = 4,
   parameter int STABLE     = 3,
   parameter int HOLD_TICKS = 50
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              TICK,
   input  logic [N_KEYS-1:0] KEY_IN,
   output logic [N_KEYS-1:0] KEY_LVL,
   output logic [N_KEYS-1:0] KEY_PRESS,
   output logic [N_KEYS-1:0] KEY_RELEASE,
   output logic [N_KEYS-1:0] KEY_LONG
);

   // Counter compare points, sized to the counter widths.
   localparam logic [3:0] STB_LAST  = 4'(STABLE - 1);
   localparam logic [9:0] HOLD_MAX  = 10'(HOLD_TICKS);
   localparam logic [9:0] HOLD_LAST = 10'(HOLD_TICKS - 1);

   // ------------------------------------------------------------------
   // Synchroniser and edge-detect registers
   // ------------------------------------------------------------------
   logic [1:0]        r_tick_sync;   // [0] meta, [1] synchronised
   logic              r_tick_d;      // previous synchronised TICK
   logic              r_tick_ev;     // registered rising-edge strobe
   logic [N_KEYS-1:0] r_key_meta;
   logic [N_KEYS-1:0] r_key_sync;    // synchronised raw keys, active-low

   // ------------------------------------------------------------------
   // Per-key state
   // ------------------------------------------------------------------
   logic [N_KEYS-1:0][3:0] r_stb_cnt;
   logic [N_KEYS-1:0][9:0] r_hold_cnt;
   logic [N_KEYS-1:0]      r_key_lvl;
   logic [N_KEYS-1:0]      r_key_press;
   logic [N_KEYS-1:0]      r_key_release;
   logic [N_KEYS-1:0]      r_key_long;

   // ------------------------------------------------------------------
   // Next-state wires
   // ------------------------------------------------------------------
   logic [N_KEYS-1:0]      w_pressed;     // synchronised key, active-high
   logic [N_KEYS-1:0]      w_disagree;
   logic [N_KEYS-1:0]      w_flip;        // debounced level toggles this tick
   logic [N_KEYS-1:0][3:0] w_stb_nxt;
   logic [N_KEYS-1:0][9:0] w_hold_nxt;
   logic [N_KEYS-1:0]      w_lvl_nxt;
   logic [N_KEYS-1:0]      w_press_nxt;
   logic [N_KEYS-1:0]      w_release_nxt;
   logic [N_KEYS-1:0]      w_long_nxt;

   assign w_pressed = ~r_key_sync;

   // TICK pipeline: two sync flops, a delay flop and the registered edge.
   // The three TICK flops reset high so a TICK already high when reset is
   // released never looks like a rising edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_tick_sync <= 2'b11;
         r_tick_d    <= 1'b1;
         r_tick_ev   <= 1'b0;
      end else begin
         r_tick_sync <= {r_tick_sync[0], TICK};
         r_tick_d    <= r_tick_sync[1];
         r_tick_ev   <= r_tick_sync[1] & ~r_tick_d;
      end
   end

   // Key synchronisers; reset to the released (high) contact state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_key_meta <= {N_KEYS{1'b1}};
         r_key_sync <= {N_KEYS{1'b1}};
      end else begin
         r_key_meta <= KEY_IN;
         r_key_sync <= r_key_meta;
      end
   end

   // Decide per key whether this tick completes a run of disagreeing samples.
   always_comb begin
      w_disagree = '0;
      w_flip     = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         w_disagree[k] = (w_pressed[k] != r_key_lvl[k]);
         if (r_tick_ev && w_disagree[k] && (r_stb_cnt[k] == STB_LAST)) begin
            w_flip[k] = 1'b1;
         end else begin
            w_flip[k] = 1'b0;
         end
      end
   end

   // Stability counter, level and press/release pulses.
   always_comb begin
      w_stb_nxt     = r_stb_cnt;
      w_lvl_nxt     = r_key_lvl;
      w_press_nxt   = '0;
      w_release_nxt = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         if (!r_tick_ev) begin
            w_stb_nxt[k] = r_stb_cnt[k];
         end else if (!w_disagree[k]) begin
            // Any agreeing sample restarts the run.
            w_stb_nxt[k] = 4'd0;
         end else if (w_flip[k]) begin
            w_stb_nxt[k] = 4'd0;
            w_lvl_nxt[k] = ~r_key_lvl[k];
            if (w_pressed[k]) begin
               w_press_nxt[k] = 1'b1;
            end else begin
               w_release_nxt[k] = 1'b1;
            end
         end else begin
            w_stb_nxt[k] = r_stb_cnt[k] + 4'd1;
         end
      end
   end

   // Hold counter and long-press pulse. The counter is zero while released
   // and on the press tick itself; it also clears on the release tick so a
   // release can never coincide with a long-press.
   always_comb begin
      w_hold_nxt = r_hold_cnt;
      w_long_nxt = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         if (!r_tick_ev) begin
            w_hold_nxt[k] = r_hold_cnt[k];
         end else if (!r_key_lvl[k] || w_flip[k]) begin
            w_hold_nxt[k] = 10'd0;
         end else if (r_hold_cnt[k] < HOLD_MAX) begin
            w_hold_nxt[k] = r_hold_cnt[k] + 10'd1;
            if (r_hold_cnt[k] == HOLD_LAST) begin
               w_long_nxt[k] = 1'b1;
            end else begin
               w_long_nxt[k] = 1'b0;
            end
         end else begin
            // Saturated: no further long-press until released.
            w_hold_nxt[k] = r_hold_cnt[k];
         end
      end
   end

   // Per-key state and output registers; pulses default to zero each cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stb_cnt     <= '0;
         r_hold_cnt    <= '0;
         r_key_lvl     <= '0;
         r_key_press   <= '0;
         r_key_release <= '0;
         r_key_long    <= '0;
      end else begin
         r_stb_cnt     <= w_stb_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_key_lvl     <= w_lvl_nxt;
         r_key_press   <= w_press_nxt;
         r_key_release <= w_release_nxt;
         r_key_long    <= w_long_nxt;
      end
   end

   assign KEY_LVL     = r_key_lvl;
   assign KEY_PRESS   = r_key_press;
   assign KEY_RELEASE = r_key_release;
   assign KEY_LONG    = r_key_long;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces and edge-classifies the raw alarm-panel keys.
- Sits directly downstream of the 50 Hz clock divider and uses its divided-clock output as a sampling strobe on the system clock. It does not clock anything from the divided clock.
- Produces clean key levels plus single-cycle press, release and long-press events for the alarm control FSM.

Parameters:
- N_KEYS, 4, number of independent key inputs.
- STABLE, 3, consecutive tick samples that must disagree with the current debounced state before that state flips (legal range 1..15).
- HOLD_TICKS, 50, ticks a key must stay debounced-pressed before KEY_LONG fires (50 ticks = 1 s at 50 Hz; legal range 1..1023).

Ports:
- CLK, input, 1, system clock.
- RST, input, 1, asynchronous reset, active-high.
- TICK, input, 1, divided-clock level from the divider. Asynchronous to this logic's view; only its rising edges matter.
- KEY_IN, input, N_KEYS, raw key contacts, active-low (0 = pressed). Asynchronous.
- KEY_LVL, output, N_KEYS, debounced level, active-high (1 = pressed).
- KEY_PRESS, output, N_KEYS, one-CLK pulse when KEY_LVL goes 0->1.
- KEY_RELEASE, output, N_KEYS, one-CLK pulse when KEY_LVL goes 1->0.
- KEY_LONG, output, N_KEYS, one-CLK pulse, at most once per press, when the hold count reaches HOLD_TICKS.

Behaviour:

Reset:
- RST high asynchronously clears KEY_LVL, KEY_PRESS, KEY_RELEASE and KEY_LONG to 0.
- All stability and hold counters clear to 0.
- KEY_IN synchroniser flops reset to 1 (released).
- All three TICK pipeline flops reset to 1, so a TICK already high at reset release creates no event.
- Reset mid-operation aborts everything. No pulse is emitted during or on exit from reset.

Input synchronisation:
- TICK and each KEY_IN bit pass through 2 flops. Call the synchronised key sample s.
- A third TICK flop gives a rising-edge detect, tick_ev, which is high for exactly one CLK per TICK rising edge.
- All key state advances only in cycles where tick_ev = 1. Outside those cycles all state holds and all pulses are 0.

Per-key stability counter (width 4), evaluated each tick_ev:
- If s equals ~KEY_LVL (no disagreement), the counter clears to 0.
- Else, if counter == STABLE-1, KEY_LVL toggles, the counter clears, and the matching PRESS or RELEASE pulse asserts.
- Else, the counter increments.
- A disagreement therefore needs STABLE consecutive ticks to take effect. Any agreeing sample restarts the count.

Per-key hold counter (width 10):
- Clears whenever KEY_LVL = 0 and on the tick_ev where the key becomes pressed.
- On each later tick_ev with KEY_LVL = 1, it increments while below HOLD_TICKS and then saturates.
- KEY_LONG pulses on the tick_ev where the counter transitions HOLD_TICKS-1 -> HOLD_TICKS. It never fires again until release.
- A release before HOLD_TICKS produces no KEY_LONG.

Timing:
- All outputs are registered.
- Pulses and the KEY_LVL change appear in the CLK cycle after the tick_ev cycle and last exactly 1 CLK.
- Latency from a TICK rising edge to output is 4 CLK: 2 sync, 1 edge, 1 output.

Independence and simultaneity:
- Keys are fully independent. Several keys may pulse in the same cycle.
- KEY_PRESS and KEY_RELEASE of one key are never both high.
- KEY_LONG never coincides with KEY_PRESS of the same key, since HOLD_TICKS >= 1.

No TICK activity:
- If TICK stops toggling, outputs freeze. No timeout applies.

Test Plan (defaults; TICK square wave, period 20 CLK, bench-driven):
1. Reset, then hold KEY_IN = 4'hF for 10 ticks -> KEY_LVL = 0 throughout; no pulses.
2. KEY_IN[0] low steadily from tick 0 -> KEY_LVL[0] = 1 and a one-CLK KEY_PRESS[0] exactly 4 CLK after the 3rd TICK rising edge; other bits stay 0.
3. KEY_IN[1] bounces low for 2 ticks, high for 1, low for 2, then high -> KEY_LVL[1] never rises; no KEY_PRESS[1].
4. Hold KEY_IN[2] low for 60 ticks, then release -> KEY_PRESS[2] once, KEY_LONG[2] once (50 ticks after the press tick), KEY_RELEASE[2] once 3 ticks after release; no second KEY_LONG.
5. Press KEY_IN[0] and KEY_IN[3] on the same TICK edge -> KEY_PRESS = 4'b1001 in a single cycle. Release both together -> KEY_RELEASE = 4'b1001 in a single cycle.
6. Assert RST for 5 CLK while key 2 is pressed with hold count at 30 -> all outputs 0 immediately. After release of RST with the key still held, a fresh KEY_PRESS[2] occurs after 3 ticks, and KEY_LONG[2] follows 50 ticks later, not 20.
